// File: rtl/geofence_pkg.sv
// Purpose: shared constants, ROM word layout and FSM encoding for the geofence feeder.
// Latency: n/a (types, constants and field helpers only).
// Backpressure: n/a.
package geofence_pkg;

  localparam int PTS_PER_ROUND = 7;
  localparam int COORD_W       = 10;
  localparam int WORD_W        = 21;

  // ROM word: {exp, X, Y}; exp is only meaningful in word 0 of a round
  localparam int EXP_BIT = 20;
  localparam int X_LSB   = 10;
  localparam int Y_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_WAIT,
    ST_FINISH
  } state_t;

  function automatic logic [COORD_W-1:0] word_x(input logic [WORD_W-1:0] w);
    return w[X_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] word_y(input logic [WORD_W-1:0] w);
    return w[Y_LSB +: COORD_W];
  endfunction

  function automatic logic word_exp(input logic [WORD_W-1:0] w);
    return w[EXP_BIT];
  endfunction

endpackage

// File: rtl/geofence_feeder_addr.sv
// Purpose: ROM address counter, point-in-round index (wraps 6->0) and round counter.
// Latency: all outputs are registers, updated on the edge after the enable.
// Backpressure: none; the owning FSM gates every increment.
module geofence_feeder_addr
  import geofence_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              addr_inc,
  input  logic              pt_inc,
  input  logic              round_inc,
  output logic [ADDR_W-1:0] addr,
  output logic              pt_last,
  output logic [7:0]        round_idx
);

  logic [2:0] pt_idx;

  assign pt_last = (pt_idx == 3'(PTS_PER_ROUND - 1));

  // Counter pair plus round count; clr parks everything at zero between runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      pt_idx    <= '0;
      round_idx <= '0;
    end else if (clr) begin
      addr      <= '0;
      pt_idx    <= '0;
      round_idx <= '0;
    end else begin
      if (addr_inc)  addr      <= addr + ADDR_W'(1);
      if (pt_inc)    pt_idx    <= pt_last ? 3'd0 : pt_idx + 3'd1;
      if (round_inc) round_idx <= round_idx + 8'd1;
    end
  end

endmodule

// File: rtl/geofence_feeder.sv
// Purpose: replays 7-point rounds from a 1-cycle ROM onto X/Y, scores is_inside vs exp, watchdogs valid.
// Latency: start edge E0 -> busy at E0, gf_reset low with point 0 at E1; final valid at d -> done at d+1.
// Backpressure: none; the consumer paces rounds only through valid, bounded by the TIMEOUT watchdog.
module geofence_feeder
  import geofence_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         num_rounds,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_rdata,
  output logic               gf_reset,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               valid,
  input  logic               is_inside,
  output logic               busy,
  output logic               done,
  output logic [7:0]         pass_cnt,
  output logic [7:0]         fail_cnt,
  output logic               mismatch,
  output logic               timeout,
  output logic               proto_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [7:0]      nr_q;
  logic            exp_cur, exp_next;
  logic [WD_W-1:0] wcnt;
  logic [7:0]      round_idx;
  logic            pt_last, last_round, start_acc;
  logic            addr_inc, pt_inc, round_inc, clr;
  logic            load_pt, load_head, score, to_fire, go_finish;

  assign busy       = (state != ST_IDLE);
  assign start_acc  = (state == ST_IDLE) && start;
  assign last_round = (round_idx == nr_q - 8'd1);

  geofence_feeder_addr #(.ADDR_W(ADDR_W)) u_addr (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (clr),
    .addr_inc  (addr_inc),
    .pt_inc    (pt_inc),
    .round_inc (round_inc),
    .addr      (mem_addr),
    .pt_last   (pt_last),
    .round_idx (round_idx)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle strobes; the address runs two cycles ahead of X/Y and
  // parks on point 1 of the next round during WAIT so no bubble follows valid
  always_comb begin
    state_nxt = state;
    addr_inc  = 1'b0;
    pt_inc    = 1'b0;
    round_inc = 1'b0;
    clr       = 1'b0;
    load_pt   = 1'b0;
    load_head = 1'b0;
    score     = 1'b0;
    to_fire   = 1'b0;
    go_finish = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && num_rounds != 8'd0) begin
          addr_inc  = 1'b1;
          state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        addr_inc  = 1'b1;
        load_pt   = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        pt_inc = 1'b1;
        if (!pt_last) begin
          addr_inc = 1'b1;
          load_pt  = 1'b1;
        end else begin
          // Preload the next round's point 0 so it is already on X/Y when valid lands
          load_pt   = !last_round;
          load_head = !last_round;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (valid) begin
          score     = 1'b1;
          round_inc = 1'b1;
          if (last_round) begin
            go_finish = 1'b1;
            state_nxt = ST_FINISH;
          end else begin
            addr_inc  = 1'b1;
            state_nxt = ST_STREAM;
          end
        end else if (wcnt == WD_W'(TIMEOUT - 1)) begin
          to_fire   = 1'b1;
          go_finish = 1'b1;
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        clr       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, expected-bit pipeline, scoring, watchdog and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      X         <= '0;
      Y         <= '0;
      gf_reset  <= 1'b1;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      nr_q      <= '0;
      exp_cur   <= 1'b0;
      exp_next  <= 1'b0;
      wcnt      <= '0;
    end else begin
      done     <= go_finish || (start_acc && num_rounds == 8'd0);
      mismatch <= score && (is_inside != exp_cur);
      wcnt     <= (state == ST_WAIT) ? wcnt + WD_W'(1) : '0;
      if (load_pt) begin
        X <= word_x(mem_rdata);
        Y <= word_y(mem_rdata);
      end
      if (state == ST_PRIME) begin
        exp_cur  <= word_exp(mem_rdata);
        gf_reset <= 1'b0;
      end
      if (load_head) exp_next <= word_exp(mem_rdata);
      if (go_finish) gf_reset <= 1'b1;
      if (score) begin
        exp_cur <= exp_next;
        if (is_inside == exp_cur) pass_cnt <= pass_cnt + 8'd1;
        else                      fail_cnt <= fail_cnt + 8'd1;
      end
      if (to_fire) timeout <= 1'b1;
      if (start_acc) begin
        nr_q      <= num_rounds;
        pass_cnt  <= '0;
        fail_cnt  <= '0;
        timeout   <= 1'b0;
        proto_err <= 1'b0;
      end
      // A stray strobe outside WAIT wins over the clear from a same-cycle start
      if (valid && state != ST_WAIT) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_geofence_feeder.sv
// Purpose: randomized and directed run schedules checked every cycle against a schedule-level reference.
// Latency: n/a (testbench).
// Backpressure: n/a; valid strobes are placed by the bench at chosen WAIT latencies.
module tb_geofence_feeder;

  localparam int TOUT = 20;
  localparam int BIG  = 1000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_rounds;
  logic [10:0] mem_addr;
  logic [20:0] mem_rdata;
  logic        gf_reset;
  logic [9:0]  X, Y;
  logic        valid, is_inside;
  logic        busy, done, mismatch, timeout, proto_err;
  logic [7:0]  pass_cnt, fail_cnt;

  logic [20:0] rom [0:2047];

  int cyc = 0;
  bit active = 1'b0;
  int win [16];
  int v   [16];
  int lat [16];
  bit ins [16];
  int n_s, base_s, fin_s;
  bit to_run;
  int first_x, first_y, done_cyc, to_cyc, mm_seen;
  int n_cmp = 0;
  int n_fail = 0;

  geofence_feeder #(.ADDR_W(11), .TIMEOUT(TOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_rounds (num_rounds),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .gf_reset   (gf_reset),
    .X          (X),
    .Y          (Y),
    .valid      (valid),
    .is_inside  (is_inside),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .mismatch   (mismatch),
    .timeout    (timeout),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  // Synchronous pattern ROM with one cycle of read latency
  always @(posedge clk) mem_rdata <= rom[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".gf_reset"}, 32'(gf_reset), 32'd1);
    chk({tag, ".X"}, 32'(X), 32'd0);
    chk({tag, ".Y"}, 32'(Y), 32'd0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".mismatch"}, 32'(mismatch), 32'd0);
    chk({tag, ".timeout"}, 32'(timeout), 32'd0);
    chk({tag, ".proto_err"}, 32'(proto_err), 32'd0);
    chk({tag, ".pass_cnt"}, 32'(pass_cnt), 32'd0);
    chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'd0);
  endtask

  // Reference: every output is derived from the run schedule (window starts, valid cycles, finish cycle)
  always @(negedge clk) begin : cmp
    int c, rr, k, idx, ep, ef;
    bit emm, egr;
    if (active && cyc >= base_s && cyc <= fin_s + 1) begin
      c = cyc;
      ep = 0; ef = 0; emm = 1'b0;
      for (int r = 0; r < n_s; r++) begin
        if (v[r] < c) begin
          if (ins[r] == rom[7*r][20]) ep++; else ef++;
          if (v[r] + 1 == c && ins[r] != rom[7*r][20]) emm = 1'b1;
        end
      end
      egr = !(c >= base_s + 1 && c <= fin_s - 1);
      chk("busy", 32'(busy), 32'(n_s != 0 && c <= fin_s));
      chk("done", 32'(done), 32'(c == fin_s));
      chk("gf_reset", 32'(gf_reset), 32'(egr));
      if (!egr) begin
        rr = 0;
        for (int r = 0; r < n_s; r++) if (win[r] <= c) rr = r;
        k = c - win[rr];
        if (k < 7)             idx = 7*rr + k;
        else if (rr < n_s - 1) idx = 7*(rr + 1);
        else                   idx = 7*rr + 6;
        chk("X", 32'(X), 32'(rom[idx][19:10]));
        chk("Y", 32'(Y), 32'(rom[idx][9:0]));
      end
      chk("pass_cnt", 32'(pass_cnt), 32'(ep));
      chk("fail_cnt", 32'(fail_cnt), 32'(ef));
      chk("mismatch", 32'(mismatch), 32'(emm));
      chk("timeout", 32'(timeout), 32'(to_run && c >= fin_s));
      chk("proto_err", 32'(proto_err), 32'd0);
      if (n_s == 0) chk("mem_addr", 32'(mem_addr), 32'd0);
      if (c == base_s + 1) begin first_x = int'(X); first_y = int'(Y); end
      if (done && done_cyc < 0) done_cyc = c;
      if (timeout && to_cyc < 0) to_cyc = c;
      if (mismatch) mm_seen++;
    end
  end

  // One run: start pulse, valid at scheduled cycles, stray starts while busy, optional mid-run reset
  task automatic run(input int n, input int to_r, input int abort_r);
    int nxt;
    bit stop, aborted;
    @(posedge clk); #1;
    start = 1'b1;
    num_rounds = 8'(n);
    base_s = cyc + 1;
    n_s = n;
    to_run = (to_r >= 0);
    for (int r = 0; r < 16; r++) begin win[r] = BIG; v[r] = BIG; end
    nxt = base_s + 1;
    fin_s = base_s;
    stop = 1'b0;
    for (int r = 0; r < n; r++) begin
      if (!stop) begin
        win[r] = nxt;
        if (r == to_r) begin
          fin_s = nxt + 7 + TOUT;
          stop = 1'b1;
        end else begin
          v[r] = nxt + 6 + lat[r];
          nxt = v[r] + 1;
          fin_s = nxt;
        end
      end
    end
    done_cyc = -1; to_cyc = -1; first_x = -1; first_y = -1; mm_seen = 0;
    aborted = 1'b0;
    active = 1'b1;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      valid = 1'b0;
      is_inside = 1'($urandom);
      for (int r = 0; r < n; r++) if (v[r] == cyc) begin valid = 1'b1; is_inside = ins[r]; end
      if (n != 0 && cyc <= fin_s && $urandom_range(0, 5) == 0) begin
        start = 1'b1;
        num_rounds = 8'($urandom);
      end
      if (abort_r >= 0 && cyc == win[abort_r] + 3) begin
        active = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_vals("mid_run");
        aborted = 1'b1;
        @(posedge clk); #3 reset = 1'b1;
      end
    end while (!aborted && cyc < fin_s + 1);
    if (!aborted) begin @(negedge clk); #1; end
    active = 1'b0;
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 128; i++) rom[i] = 21'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; is_inside = 1'b0; num_rounds = 8'd0;
    for (int i = 0; i < 2048; i++) rom[i] = 21'($urandom);
    #2 reset = 1'b0;
    #1 chk_reset_vals("por");
    #20 reset = 1'b1;

    // Object (100,100) inside a hexagon, exp=1, result after 3 WAIT cycles
    rom[0] = {1'b1, 10'd100, 10'd100};
    rom[1] = {1'b0, 10'd75,  10'd50};
    rom[2] = {1'b0, 10'd125, 10'd50};
    rom[3] = {1'b0, 10'd150, 10'd100};
    rom[4] = {1'b0, 10'd125, 10'd150};
    rom[5] = {1'b0, 10'd75,  10'd150};
    rom[6] = {1'b0, 10'd50,  10'd100};
    lat[0] = 3; ins[0] = 1'b1;
    run(1, -1, -1);
    chk("hex.pass_cnt", 32'(pass_cnt), 32'd1);
    chk("hex.fail_cnt", 32'(fail_cnt), 32'd0);
    chk("hex.first_x", 32'(first_x), 32'd100);
    chk("hex.first_y", 32'(first_y), 32'd100);
    chk("hex.done_ofs", 32'(done_cyc - base_s), 32'd11);

    // Same round with a wrong expected bit
    rom[0] = {1'b0, 10'd100, 10'd100};
    run(1, -1, -1);
    chk("badexp.fail_cnt", 32'(fail_cnt), 32'd1);
    chk("badexp.pass_cnt", 32'(pass_cnt), 32'd0);
    chk("badexp.mm_seen", 32'(mm_seen), 32'd1);

    // Three rounds back-to-back with the shortest and a medium WAIT
    fill_rom();
    lat[0] = 1; lat[1] = 5; lat[2] = 1;
    for (int r = 0; r < 3; r++) ins[r] = 1'($urandom);
    run(3, -1, -1);
    chk("b2b.done_ofs", 32'(done_cyc - base_s), 32'd29);

    // Stray valid while idle raises the sticky protocol flag
    @(posedge clk); #1 valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk); #1;
    chk("proto.proto_err", 32'(proto_err), 32'd1);

    // Zero rounds: done right after start, nothing streamed
    run(0, -1, -1);
    chk("zero.done_ofs", 32'(done_cyc - base_s), 32'd0);

    // Consumer goes silent on round 1
    fill_rom();
    lat[0] = 4; lat[1] = 0; lat[2] = 4;
    for (int r = 0; r < 3; r++) ins[r] = 1'($urandom);
    run(3, 1, -1);
    chk("tout.to_ofs", 32'(to_cyc - base_s), 32'd39);
    chk("tout.timeout", 32'(timeout), 32'd1);
    chk("tout.gf_reset", 32'(gf_reset), 32'd1);

    // Randomized runs
    for (int t = 0; t < 12; t++) begin
      int n;
      fill_rom();
      n = $urandom_range(1, 6);
      for (int r = 0; r < 16; r++) begin
        lat[r] = $urandom_range(1, 15);
        ins[r] = 1'($urandom);
      end
      run(n, -1, -1);
    end

    // Asynchronous reset during round 2 streaming, then a clean rerun
    fill_rom();
    for (int r = 0; r < 16; r++) begin
      lat[r] = $urandom_range(1, 10);
      ins[r] = 1'($urandom);
    end
    run(3, -1, 1);
    run(3, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
